// File: rtl/fetch_unit.sv
// Instruction-fetch control: drives the PC's next-address/hold inputs and owns the IF/ID register.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_address,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
`endif
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic        run;
    logic        redirect;
    logic        stall_run;
    logic        normal;

    assign pc_plus4  = pc_address + 32'd4;
    assign run       = (state_q == RUN);
    assign redirect  = run && (branch_taken || jump);
    assign stall_run = run && !redirect && stall;
    assign normal    = run && !redirect && !stall;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        pc_next = pc_plus4;
        pc_hold = 1'b0;
        case (state_q)
            BOOT: begin
                // Inputs from ID/hazard logic are meaningless until the first fetch.
                pc_next = RESET_VECTOR;
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_next = branch_taken ? branch_target : jump_target;
                    instr_d = NOP_INSTR;
                    pc4_d   = 32'd0;
                    valid_d = 1'b0;
                end else if (stall) begin
                    pc_hold = 1'b1;
                end else begin
                    instr_d = instr_in;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, stalls_q, flushes_q;

    // Counters saturate rather than wrap so long runs never report small numbers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= 32'd0;
            stalls_q  <= 32'd0;
            flushes_q <= 32'd0;
        end else begin
            if (normal && fetched_q != 32'hFFFF_FFFF)
                fetched_q <= fetched_q + 32'd1;
            if (stall_run && stalls_q != 32'hFFFF_FFFF)
                stalls_q <= stalls_q + 32'd1;
            if (redirect && flushes_q != 32'hFFFF_FFFF)
                flushes_q <= flushes_q + 32'd1;
        end
    end

    assign perf_fetched      = fetched_q;
    assign perf_stall_cycles = stalls_q;
    assign perf_flushes      = flushes_q;
`else
    logic unused_run_flags;
    assign unused_run_flags = stall_run ^ normal;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural model checked every negedge plus literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_address = 0;
    logic [31:0] instr_in = 0;
    logic        stall = 0;
    logic        branch_taken = 0;
    logic [31:0] branch_target = 0;
    logic        jump = 0;
    logic [31:0] jump_target = 0;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall_cycles, perf_flushes;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    fetch_unit #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc_address(pc_address), .instr_in(instr_in),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .pc_next(pc_next), .pc_hold(pc_hold),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "fetched since boot" flag, the IF/ID contents, and event tallies.
    bit          m_booted = 0;
    logic [31:0] m_instr = NOP, m_pc4 = 0;
    logic        m_valid = 0;
    int unsigned m_fetched = 0, m_stalls = 0, m_flushes = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_booted = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0;
            m_fetched = 0; m_stalls = 0; m_flushes = 0;
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (branch_taken || jump) begin
            m_instr = NOP; m_pc4 = 0; m_valid = 0; m_flushes++;
        end else if (stall) begin
            m_stalls++;
        end else begin
            m_instr = instr_in; m_pc4 = pc_address + 32'd4; m_valid = 1; m_fetched++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] e_next;
            logic        e_hold;
            if (!m_booted)          e_next = RV;
            else if (branch_taken)  e_next = branch_target;
            else if (jump)          e_next = jump_target;
            else                    e_next = pc_address + 32'd4;
            e_hold = m_booted && !branch_taken && !jump && stall;
            check("cmp_pc_next", pc_next, e_next);
            check("cmp_pc_hold", {31'd0, pc_hold}, {31'd0, e_hold});
            check("cmp_if_id_instr", if_id_instr, m_instr);
            check("cmp_if_id_pc4", if_id_pc4, m_pc4);
            check("cmp_if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
            check("cmp_perf_fetched", perf_fetched, m_fetched);
            check("cmp_perf_stalls", perf_stall_cycles, m_stalls);
            check("cmp_perf_flushes", perf_flushes, m_flushes);
`endif
        end
    end

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic st,
                         input logic br, input logic [31:0] bt, input logic jp,
                         input logic [31:0] jt);
        pc_address = pc; instr_in = ins; stall = st;
        branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic normal(input logic [31:0] pc, input logic [31:0] ins);
        drive(pc, ins, 0, 0, 0, 0, 0);
        check("seq_pc_next", pc_next, pc + 32'd4);
        edge_step();
        check("seq_instr", if_id_instr, ins);
        check("seq_pc4", if_id_pc4, pc + 32'd4);
        $display("normal pc=%h instr=%h -> pc4=%h valid=%b", pc, ins, if_id_pc4, if_id_valid);
    endtask

    initial begin
        #1 reset = 1'b1;
        cmp_en = 1;
        edge_step();
        edge_step();
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_pc_hold", {31'd0, pc_hold}, 32'd0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        reset = 1'b0;
        // Boot cycle: redirect/stall requests must be ignored.
        drive(32'h1234, 32'hDEAD_BEEF, 1, 1, 32'h55, 1, 32'h77);
        check("boot_pc_next", pc_next, 32'h0);
        check("boot_pc_hold", {31'd0, pc_hold}, 32'd0);
        edge_step();
        check("boot_valid", {31'd0, if_id_valid}, 32'd0);
        $display("boot pc_next=%h valid=%b", pc_next, if_id_valid);

        drive(32'h0, 32'h2008_0005, 0, 0, 0, 0, 0);
        check("first_pc_next", pc_next, 32'h4);
        edge_step();
        check("first_instr", if_id_instr, 32'h2008_0005);
        check("first_pc4", if_id_pc4, 32'h4);
        check("first_valid", {31'd0, if_id_valid}, 32'd1);
        $display("first fetch instr=%h pc4=%h", if_id_instr, if_id_pc4);

        normal(32'h4, 32'h1111_0004);
        for (int i = 0; i < 2; i++) begin
            drive(32'h8, 32'h2222_0008, 1, 0, 0, 0, 0);
            check("stall_hold", {31'd0, pc_hold}, 32'd1);
            edge_step();
            check("stall_instr", if_id_instr, 32'h1111_0004);
            check("stall_pc4", if_id_pc4, 32'h8);
            $display("stall pc=8 hold=%b pc4=%h", pc_hold, if_id_pc4);
        end
        normal(32'h8, 32'h2222_0008);
        check("stall_release_pc4", if_id_pc4, 32'hC);
        normal(32'hC, 32'h3333_000C);

        drive(32'h10, 32'h4444_0010, 1, 1, 32'h40, 1, 32'h100);
        check("prio_pc_next", pc_next, 32'h40);
        check("prio_pc_hold", {31'd0, pc_hold}, 32'd0);
        edge_step();
        check("prio_instr", if_id_instr, 32'h0);
        check("prio_valid", {31'd0, if_id_valid}, 32'd0);
        $display("redirect branch pc_next=40 valid=%b", if_id_valid);
        drive(32'h40, 32'h5555_0040, 0, 0, 0, 1, 32'h200);
        check("jump_pc_next", pc_next, 32'h200);
        edge_step();
        check("b2b_valid1", {31'd0, if_id_valid}, 32'd0);
        drive(32'h200, 32'h6666_0200, 0, 1, 32'h80, 0, 0);
        check("branch_pc_next", pc_next, 32'h80);
        edge_step();
        check("b2b_valid2", {31'd0, if_id_valid}, 32'd0);
        $display("back-to-back redirects valid=%b", if_id_valid);
        normal(32'h80, 32'h7777_0080);

        drive(32'hFFFF_FFFC, 32'h8888_FFFC, 0, 0, 0, 0, 0);
        check("wrap_pc_next", pc_next, 32'h0);
        edge_step();
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_valid", {31'd0, if_id_valid}, 32'd1);
        $display("wrap pc4=%h", if_id_pc4);

        drive(32'h0, 32'h9999_0000, 1, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'd0, if_id_valid}, 32'd0);
        check("async_instr", if_id_instr, NOP);
        check("async_pc4", if_id_pc4, 32'h0);
        $display("async reset valid=%b", if_id_valid);
        edge_step();
        reset = 1'b0;
        drive(32'h0, 32'h0, 0, 1, 32'h44, 0, 0);
        check("reboot_pc_next", pc_next, RV);
        edge_step();

        for (int i = 0; i < 5; i++) normal(32'h100 + 4 * i, 32'hA000_0000 + i);
        for (int i = 0; i < 3; i++) begin
            drive(32'h114, 32'hB000_0000, 1, 0, 0, 0, 0);
            edge_step();
        end
        drive(32'h114, 32'hB000_0000, 1, 1, 32'h300, 0, 0);
        edge_step();
        drive(32'h300, 32'hB000_0001, 0, 0, 0, 1, 32'h400);
        edge_step();
        check("perf_valid_after", {31'd0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_stall_cycles", perf_stall_cycles, 32'd3);
        check("perf_flushes", perf_flushes, 32'd2);
        $display("perf fetched=%0d stalls=%0d flushes=%0d", perf_fetched, perf_stall_cycles, perf_flushes);
`endif
        drive(32'h400, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch control stage wrapped around the program-counter register.
- Upstream of the PC: generates the PC's next-address and hold inputs.
- Downstream of the PC: captures the fetched instruction and PC+4 into the IF/ID pipeline register.
- Arbitrates reset boot, load-use stalls and branch/jump redirects, and inserts bubbles (flush) on redirect.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID on a bubble.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- pc_address  input  32  current PC register value.
- instr_in  input  32  instruction-memory read data for pc_address, combinational same cycle.
- stall  input  1  hazard-unit load-use stall request.
- branch_taken  input  1  branch resolved taken in ID.
- branch_target  input  32  branch destination.
- jump  input  1  jump decoded in ID.
- jump_target  input  32  jump destination.
- pc_next  output  32  next-address input to the PC register.
- pc_hold  output  1  hold input to the PC register.
- if_id_instr  output  32  IF/ID instruction.
- if_id_pc4  output  32  IF/ID PC+4.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is asynchronous and active-high, named reset.
  - All registers clear immediately on reset assertion, independent of clk.
- Reset values:
  - if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0.
  - FSM=BOOT.
- FSM state BOOT:
  - Drives pc_next=RESET_VECTOR, pc_hold=0.
  - IF/ID keeps its bubble.
  - Exactly one clock in BOOT after reset deassertion, then RUN.
  - stall, branch_taken and jump are ignored in BOOT.
- FSM state RUN, evaluated each cycle, priority high to low:
  1. Redirect (branch_taken or jump):
     - pc_next = branch_target if branch_taken, else jump_target. branch_taken beats jump when both are high.
     - pc_hold=0.
     - Next edge: IF/ID loads NOP_INSTR, if_id_pc4=0, if_id_valid=0. The wrong-path instruction is flushed.
     - A redirect overrides a simultaneous stall: the stall is dropped.
  2. Stall:
     - pc_hold=1; pc_next=pc_address+4 (don't-care to the PC).
     - All IF/ID registers hold their values.
  3. Normal:
     - pc_next=pc_address+4, pc_hold=0.
     - Next edge: if_id_instr<=instr_in, if_id_pc4<=pc_address+4, if_id_valid<=1.
- RUN persists until reset.
- pc_next and pc_hold are combinational from the current state and inputs; IF/ID is registered.
- Fetch-to-IF/ID latency: 1 cycle.
- Redirect penalty: exactly one bubble.
- Arithmetic:
  - PC+4 is a 32-bit modulo add; 32'hFFFF_FFFC+4 wraps to 0.
  - Targets pass through unmodified; alignment is the decoder's job.
- Reset asserted mid-stall or mid-redirect: IF/ID clears at once and the FSM returns to BOOT. No pending redirect survives.
- Back-to-back redirects on consecutive cycles each flush; if_id_valid stays 0 throughout.
- A stall held indefinitely freezes pc_address and IF/ID indefinitely. There is no timeout.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, all cleared by reset and saturating at 32'hFFFF_FFFF:
  - perf_fetched: increments on each normal IF/ID load.
  - perf_stall_cycles: increments each RUN cycle with a stall and no redirect.
  - perf_flushes: increments on each redirect.
- When undefined:
  - The ports and counters do not exist.
  - Core behaviour is identical.

Test Plan:
- Boot: assert reset for 2 cycles, release with RESET_VECTOR=0.
  - Reset cycles and first cycle after release: pc_next=0, pc_hold=0, if_id_valid=0.
  - Next cycle: pc_address=0, instr_in=32'h2008_0005; after the edge, if_id_instr=32'h2008_0005, if_id_pc4=4, if_id_valid=1.
- Sequential: run from PC 0 with no stall.
  - pc_next sequence is 4, 8, 12.
  - IF/ID tracks each instruction one cycle later.
- Stall: pc_address=8 with stall=1 for 2 cycles.
  - pc_hold=1 both cycles.
  - if_id_instr and if_id_pc4=8 unchanged.
  - After release, pc_next=12.
- Redirect priority: pc_address=16, branch_taken=1, branch_target=32'h40, jump=1, jump_target=32'h100, stall=1.
  - pc_next=32'h40, pc_hold=0.
  - After the edge: if_id_instr=0, if_id_valid=0.
- Wrap and async reset:
  - pc_address=32'hFFFF_FFFC: pc_next=0.
  - Assert reset between clock edges: if_id_valid drops to 0 before the next posedge.
- With FETCH_PERF_CNT_EN: 5 normal fetches, 3 stall cycles, 2 redirects.
  - perf_fetched=5, perf_stall_cycles=3, perf_flushes=2.
